tff_bank_ctrl: RTL and testbench
================================

# tff_bank_ctrl

Sequencing controller for a bank of WIDTH T flip-flops that together hold a count value. Each cycle it reads the bank's current `q` vector and drives the bank's `t` vector so that the bank loads a value, counts up or down modulo a programmable limit, or holds. It sits beside the T flip-flop bank in the counter datapath. It owns all toggle decisions, so the bank itself stays a plain array of flip-flops.

## Interface
- `WIDTH`, default 4: number of T flip-flops in the controlled bank.
- `ONE_SHOT`, default 0: 0 = count continuously; 1 = stop in DONE after the first terminal count.

- `clk` in 1: clock. All state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin or resume counting.
- `stop` in 1: abort counting and return to IDLE.
- `up` in 1: count direction. 1 = up, 0 = down. Sampled every RUN cycle.
- `load` in 1: request a load of `load_val` into the bank.
- `load_val` in WIDTH: value to load.
- `limit` in WIDTH: modulus bound; the count range is 0..limit. Sampled every cycle.
- `q` in WIDTH: current bank contents, fed back from the flip-flops.
- `t` out WIDTH: toggle vector to the bank. The bank computes q_next = q ^ t.
- `busy` out 1: high in RUN or LOAD.
- `tc` out 1: terminal-count pulse.
- `done` out 1: high in DONE.

## Operation
- States: IDLE, LOAD, RUN, DONE. State is a registered value.
- `t`, `tc`, `busy` and `done` are combinational from the registered state and the current `q`, `up`, `limit` and `load_val`.
- IDLE:
  - `t`=0.
  - `load` goes to LOAD; `load` has priority over `start`.
  - Else `start` goes to RUN.
- LOAD: lasts one cycle.
  - `t` = q ^ load_val.
  - Next state is IDLE.
- RUN, counting up:
  - If q == limit: `t` = q (clears the bank to 0) and `tc`=1.
  - Else `t` is the increment mask: t[0]=1, t[i] = &q[i-1:0].
- RUN, counting down:
  - If q == 0: `t` = limit (wraps to limit) and `tc`=1.
  - Else `t` is the decrement mask: t[0]=1, t[i] = &(~q[i-1:0]).
- RUN, transitions:
  - If `stop`=1: `t`=0, `tc`=0, next state IDLE. `stop` beats `start` and beats counting.
  - If `tc`=1 and ONE_SHOT=1: next state DONE.
  - `load` is ignored in RUN.
- DONE:
  - `t`=0, `done`=1.
  - `load` goes to LOAD.
  - Else `start` goes to RUN.
  - Else `stop` goes to IDLE.
  - Otherwise stay in DONE.
- Limit changed during counting:
  - If up and q > limit: increment normally, wrapping 2^WIDTH-1 to 0 via the all-ones mask, with no `tc` until q == limit.
  - If down and q > limit: decrement normally.
- limit = 0:
  - Up: every RUN cycle has q == 0 == limit, so `t`=0 and `tc`=1.
  - Down: same result, `t`=0 and `tc`=1.

## Timing
- Reset values: state IDLE, `t`=0, `busy`=0, `tc`=0, `done`=0.
- While `rst`=1, `t` is forced to 0 in that same cycle regardless of state. Reset mid-RUN or mid-LOAD takes effect at that edge.
- Latency from `start` to the first toggle: `start` sampled in IDLE at edge N, RUN from N, first nonzero `t` in cycle N+1, bank updates at edge N+1.
- Load: `load` sampled at edge N, `t` = q ^ load_val during cycle N+1, bank holds load_val after edge N+1, IDLE again after edge N+1.
- `tc` is high for exactly the cycle in which the wrap toggle is driven. It is a single-cycle pulse unless limit = 0.
- `busy` is high during LOAD and every RUN cycle. It is low in the cycle after a `stop` is sampled.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with q=4'hA, `start`=1 and `load`=1 → `t`=0, `busy`=0, `tc`=0, `done`=0. State is IDLE after release.
- Load: q=4'h3, load_val=4'h6, pulse `load` → next cycle `t`=4'h5 and `busy`=1. The cycle after, `t`=0 and q=4'h6. Check that `load`+`start` together in IDLE selects LOAD.
- Up count: WIDTH=4, limit=9, up=1, q from 0 → `t` sequence 1,3,1,7,1,3,1,F,1. Then at q=9, `t`=9 and `tc`=1, and q returns to 0. This repeats continuously when ONE_SHOT=0.
- Down wrap: limit=5, up=0, start at q=2 → `t`=3 (q=1), `t`=1 (q=0), then `t`=5 with `tc`=1 (q=5), then `t`=1 (q=4).
- One-shot: ONE_SHOT=1, limit=2, up=1 → q steps 0,1,2, then `tc`=1 and q=0. Next state DONE: `done`=1, `t`=0 held. `start` re-enters RUN with `done`=0.
- Abort: in RUN with q=4'h5, assert `stop`+`start` together → `t`=0, `tc`=0, IDLE next cycle, q stays 5. Assert `rst` mid-RUN → `t`=0 that cycle, IDLE after the edge.

Source files
------------

// File: rtl/tff_bank_ctrl.sv
// rtl/tff_bank_ctrl.sv - toggle sequencer for a WIDTH-bit T flip-flop count bank
// Drives t so the bank (q_next = q ^ t) loads, counts modulo limit+1, or holds.
module tff_bank_ctrl #(
  parameter int WIDTH    = 4,
  parameter bit ONE_SHOT = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             up_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic [WIDTH-1:0] limit_i,
  input  logic [WIDTH-1:0] q_i,
  output logic [WIDTH-1:0] t_o,
  output logic             busy_o,
  output logic             tc_o,
  output logic             done_o
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] inc_mask;
  logic [WIDTH-1:0] dec_mask;
  logic             carry_up;
  logic             carry_dn;
  logic             run_tc;

  // Bit i toggles when all lower bits are 1 (up) or all 0 (down).
  always_comb begin
    inc_mask = '0;
    dec_mask = '0;
    carry_up = 1'b1;
    carry_dn = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      inc_mask[i] = carry_up;
      dec_mask[i] = carry_dn;
      carry_up    = carry_up & q_i[i];
      carry_dn    = carry_dn & ~q_i[i];
    end
  end

  assign run_tc = up_i ? (q_i == limit_i) : (q_i == '0);

  always_comb begin
    t_o    = '0;
    tc_o   = 1'b0;
    busy_o = 1'b0;
    done_o = 1'b0;
    if (!rst_i) begin
      case (state_q)
        S_LOAD: begin
          t_o    = q_i ^ load_val_i;
          busy_o = 1'b1;
        end
        S_RUN: begin
          busy_o = 1'b1;
          if (!stop_i) begin
            tc_o = run_tc;
            if (up_i) t_o = run_tc ? q_i : inc_mask;
            else      t_o = run_tc ? limit_i : dec_mask;
          end
        end
        S_DONE:  done_o = 1'b1;
        default: t_o = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (load_i)       state_q <= S_LOAD;
          else if (start_i) state_q <= S_RUN;
        end
        S_LOAD: state_q <= S_IDLE;
        S_RUN: begin
          if (stop_i)                 state_q <= S_IDLE;
          else if (ONE_SHOT && run_tc) state_q <= S_DONE;
        end
        S_DONE: begin
          if (load_i)       state_q <= S_LOAD;
          else if (start_i) state_q <= S_RUN;
          else if (stop_i)  state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tff_bank_ctrl.sv
// tb/tb_tff_bank_ctrl.sv - scoreboard bench for tff_bank_ctrl with modelled T flip-flop banks
module tb_tff_bank_ctrl;

  typedef struct packed {
    logic [3:0] t;
    logic       tc;
    logic       busy;
    logic       done;
    logic [3:0] q;
  } exp_t;

  typedef struct packed {
    logic       rst;
    logic       start;
    logic       stop;
    logic       load;
    logic       up;
    logic       bset;
    logic [3:0] bval;
    logic [3:0] lv;
    logic [3:0] lim;
  } stim_t;

  logic       clk = 1'b0;
  logic       rst, start, stop, up, load, bank_set;
  logic [3:0] load_val, limit, bank_val;
  logic [3:0] q0 = '0;
  logic [3:0] q1 = '0;
  logic [3:0] t0, t1;
  logic       busy0, tc0, done0, busy1, tc1, done1;
  exp_t       obs0, obs1;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  int    n_total = 0;
  int    n_pass  = 0;
  bit    sel;
  string name;

  always #5 clk = ~clk;

  tff_bank_ctrl #(.WIDTH(4), .ONE_SHOT(1'b0)) dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .up_i(up),
    .load_i(load), .load_val_i(load_val), .limit_i(limit), .q_i(q0),
    .t_o(t0), .busy_o(busy0), .tc_o(tc0), .done_o(done0)
  );

  tff_bank_ctrl #(.WIDTH(4), .ONE_SHOT(1'b1)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .up_i(up),
    .load_i(load), .load_val_i(load_val), .limit_i(limit), .q_i(q1),
    .t_o(t1), .busy_o(busy1), .tc_o(tc1), .done_o(done1)
  );

  // T flip-flop banks; bank_set preloads them directly.
  always @(posedge clk) begin
    q0 <= bank_set ? bank_val : (q0 ^ t0);
    q1 <= bank_set ? bank_val : (q1 ^ t1);
  end

  assign obs0 = {t0, tc0, busy0, done0, q0};
  assign obs1 = {t1, tc1, busy1, done1, q1};

  function automatic stim_t st(int r, int s, int p, int l, int u, int b, int bv, int lv, int lim);
    stim_t x;
    x.rst = r[0]; x.start = s[0]; x.stop = p[0]; x.load = l[0]; x.up = u[0];
    x.bset = b[0]; x.bval = bv[3:0]; x.lv = lv[3:0]; x.lim = lim[3:0];
    return x;
  endfunction

  function automatic exp_t ex(int t, int tc, int busy, int done, int q);
    exp_t x;
    x.t = t[3:0]; x.tc = tc[0]; x.busy = busy[0]; x.done = done[0]; x.q = q[3:0];
    return x;
  endfunction

  function automatic void add(stim_t s, exp_t e);
    stim_q.push_back(s);
    exp_q.push_back(e);
  endfunction

  task automatic drive(input stim_t s);
    rst = s.rst; start = s.start; stop = s.stop; load = s.load; up = s.up;
    bank_set = s.bset; bank_val = s.bval; load_val = s.lv; limit = s.lim;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e, o;
    sel = 1'b0; name = "reset";
    add(st(1,1,0,1,0,1,'hA,0,0), ex(0,0,0,0,0));
    add(st(1,1,0,1,0,0,0,0,0),   ex(0,0,0,0,'hA));
    add(st(0,0,0,0,0,0,0,0,0),   ex(0,0,0,0,'hA));
    add(st(0,0,0,0,0,0,0,0,0),   ex(0,0,0,0,'hA));
    for (int k = 0; stim_q.size() > 0; k++) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      o = sel ? obs1 : obs0;
      n_total++;
      if (o !== e)
        $display("FAIL %s step %0d: got t=%h tc=%b busy=%b done=%b q=%h, expected t=%h tc=%b busy=%b done=%b q=%h",
                 name, k, o.t, o.tc, o.busy, o.done, o.q, e.t, e.tc, e.busy, e.done, e.q);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_load();
    exp_t e, o;
    sel = 1'b0; name = "load";
    add(st(0,0,0,0,0,1,3,0,0), ex(0,0,0,0,'hA));
    add(st(0,0,0,1,0,0,0,6,0), ex(0,0,0,0,3));
    add(st(0,0,0,0,0,0,0,6,0), ex(5,0,1,0,3));
    add(st(0,1,0,1,0,0,0,9,0), ex(0,0,0,0,6));
    add(st(0,0,0,0,0,0,0,9,0), ex('hF,0,1,0,6));
    add(st(0,0,0,0,0,0,0,9,0), ex(0,0,0,0,9));
    for (int k = 0; stim_q.size() > 0; k++) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      o = sel ? obs1 : obs0;
      n_total++;
      if (o !== e)
        $display("FAIL %s step %0d: got t=%h tc=%b busy=%b done=%b q=%h, expected t=%h tc=%b busy=%b done=%b q=%h",
                 name, k, o.t, o.tc, o.busy, o.done, o.q, e.t, e.tc, e.busy, e.done, e.q);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_up_count();
    exp_t e, o;
    logic [3:0] tseq [12] = '{4'h1, 4'h3, 4'h1, 4'h7, 4'h1, 4'h3, 4'h1, 4'hF, 4'h1, 4'h9, 4'h1, 4'h3};
    int qv;
    sel = 1'b0; name = "up_count";
    add(st(0,0,0,0,1,1,0,0,9), ex(0,0,0,0,9));
    add(st(0,1,0,0,1,0,0,0,9), ex(0,0,0,0,0));
    for (int i = 0; i < 12; i++) begin
      qv = (i < 10) ? i : i - 10;
      add(st(0,0,0,0,1,0,0,0,9), ex(int'(tseq[i]), (qv == 9) ? 1 : 0, 1, 0, qv));
    end
    add(st(0,0,1,0,1,0,0,0,9), ex(0,0,1,0,2));
    add(st(0,0,0,0,1,0,0,0,9), ex(0,0,0,0,2));
    for (int k = 0; stim_q.size() > 0; k++) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      o = sel ? obs1 : obs0;
      n_total++;
      if (o !== e)
        $display("FAIL %s step %0d: got t=%h tc=%b busy=%b done=%b q=%h, expected t=%h tc=%b busy=%b done=%b q=%h",
                 name, k, o.t, o.tc, o.busy, o.done, o.q, e.t, e.tc, e.busy, e.done, e.q);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_down_wrap();
    exp_t e, o;
    sel = 1'b0; name = "down_wrap";
    add(st(0,1,0,0,0,0,0,0,5), ex(0,0,0,0,2));
    add(st(0,0,0,0,0,0,0,0,5), ex(3,0,1,0,2));
    add(st(0,0,0,0,0,0,0,0,5), ex(1,0,1,0,1));
    add(st(0,0,0,0,0,0,0,0,5), ex(5,1,1,0,0));
    add(st(0,0,0,0,0,0,0,0,5), ex(1,0,1,0,5));
    add(st(0,1,1,0,0,0,0,0,5), ex(0,0,1,0,4));
    add(st(0,0,0,0,0,0,0,0,5), ex(0,0,0,0,4));
    for (int k = 0; stim_q.size() > 0; k++) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      o = sel ? obs1 : obs0;
      n_total++;
      if (o !== e)
        $display("FAIL %s step %0d: got t=%h tc=%b busy=%b done=%b q=%h, expected t=%h tc=%b busy=%b done=%b q=%h",
                 name, k, o.t, o.tc, o.busy, o.done, o.q, e.t, e.tc, e.busy, e.done, e.q);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_abort();
    exp_t e, o;
    sel = 1'b0; name = "abort";
    add(st(0,0,0,0,1,1,5,0,5), ex(0,0,0,0,4));
    add(st(0,1,0,0,1,0,0,0,5), ex(0,0,0,0,5));
    add(st(0,1,1,0,1,0,0,0,5), ex(0,0,1,0,5));
    add(st(0,0,0,0,1,0,0,0,5), ex(0,0,0,0,5));
    add(st(0,1,0,0,1,0,0,0,5), ex(0,0,0,0,5));
    add(st(0,0,0,1,1,0,0,0,5), ex(5,1,1,0,5));
    add(st(0,0,0,0,1,0,0,0,5), ex(1,0,1,0,0));
    add(st(1,0,0,0,1,0,0,0,5), ex(0,0,0,0,1));
    add(st(0,0,0,0,1,0,0,0,5), ex(0,0,0,0,1));
    for (int k = 0; stim_q.size() > 0; k++) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      o = sel ? obs1 : obs0;
      n_total++;
      if (o !== e)
        $display("FAIL %s step %0d: got t=%h tc=%b busy=%b done=%b q=%h, expected t=%h tc=%b busy=%b done=%b q=%h",
                 name, k, o.t, o.tc, o.busy, o.done, o.q, e.t, e.tc, e.busy, e.done, e.q);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_one_shot();
    exp_t e, o;
    sel = 1'b1; name = "one_shot";
    drive(st(1,0,0,0,1,1,0,0,2));
    tick();
    add(st(0,1,0,0,1,0,0,0,2), ex(0,0,0,0,0));
    add(st(0,0,0,0,1,0,0,0,2), ex(1,0,1,0,0));
    add(st(0,0,0,0,1,0,0,0,2), ex(3,0,1,0,1));
    add(st(0,0,0,0,1,0,0,0,2), ex(2,1,1,0,2));
    add(st(0,0,0,0,1,0,0,0,2), ex(0,0,0,1,0));
    add(st(0,1,0,0,1,0,0,0,2), ex(0,0,0,1,0));
    add(st(0,0,0,0,1,0,0,0,2), ex(1,0,1,0,0));
    add(st(0,0,1,0,1,0,0,0,2), ex(0,0,1,0,1));
    add(st(0,0,0,0,1,0,0,0,2), ex(0,0,0,0,1));
    for (int k = 0; stim_q.size() > 0; k++) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      o = sel ? obs1 : obs0;
      n_total++;
      if (o !== e)
        $display("FAIL %s step %0d: got t=%h tc=%b busy=%b done=%b q=%h, expected t=%h tc=%b busy=%b done=%b q=%h",
                 name, k, o.t, o.tc, o.busy, o.done, o.q, e.t, e.tc, e.busy, e.done, e.q);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_limit_edge();
    exp_t e, o;
    sel = 1'b0; name = "limit_edge";
    drive(st(1,0,0,0,1,1,'hE,0,3));
    tick();
    add(st(0,1,0,0,1,0,0,0,3), ex(0,0,0,0,'hE));
    add(st(0,0,0,0,1,0,0,0,3), ex(1,0,1,0,'hE));
    add(st(0,0,0,0,1,0,0,0,3), ex('hF,0,1,0,'hF));
    add(st(0,0,0,0,1,0,0,0,3), ex(1,0,1,0,0));
    add(st(0,0,1,0,1,0,0,0,3), ex(0,0,1,0,1));
    add(st(0,1,0,0,0,0,0,0,0), ex(0,0,0,0,1));
    add(st(0,0,0,0,0,0,0,0,0), ex(1,0,1,0,1));
    add(st(0,0,0,0,0,0,0,0,0), ex(0,1,1,0,0));
    add(st(0,0,0,0,1,0,0,0,0), ex(0,1,1,0,0));
    add(st(0,0,1,0,1,0,0,0,0), ex(0,0,1,0,0));
    add(st(0,0,0,0,0,0,0,0,0), ex(0,0,0,0,0));
    for (int k = 0; stim_q.size() > 0; k++) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      o = sel ? obs1 : obs0;
      n_total++;
      if (o !== e)
        $display("FAIL %s step %0d: got t=%h tc=%b busy=%b done=%b q=%h, expected t=%h tc=%b busy=%b done=%b q=%h",
                 name, k, o.t, o.tc, o.busy, o.done, o.q, e.t, e.tc, e.busy, e.done, e.q);
      else n_pass++;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; up = 1'b0; load = 1'b0;
    bank_set = 1'b0; bank_val = '0; load_val = '0; limit = '0;
    test_reset();
    test_load();
    test_up_count();
    test_down_wrap();
    test_abort();
    test_one_shot();
    test_limit_edge();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
